// File: rtl/cpu_pkg.sv
// Shared EX-stage definitions: ALU op codes, multiply FSM states, EX/MEM register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int MUL_CYCLES = 32;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_AND  = 6'b000010;
  localparam logic [5:0] ALU_OR   = 6'b000011;
  localparam logic [5:0] ALU_XOR  = 6'b000100;
  localparam logic [5:0] ALU_SLT  = 6'b000101;
  localparam logic [5:0] ALU_SLL  = 6'b000110;
  localparam logic [5:0] ALU_SRL  = 6'b000111;
  localparam logic [5:0] ALU_MUL  = 6'b001000;
  localparam logic [5:0] ALU_BEQZ = 6'b001001;
  localparam logic [5:0] ALU_BNEZ = 6'b001010;
  localparam logic [5:0] ALU_JMP  = 6'b001011;
  localparam logic [5:0] ALU_NOP  = 6'b010101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_taken;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] branch_target;
    logic [4:0]  write_reg;
  } ex_mem_t;

  // Bypass mux: EX/MEM beats MEM/WB; a load sitting in EX/MEM has no data yet; r0 never bypasses.
  function automatic logic [31:0] fwd_operand(
    input ex_mem_t     ex,
    input logic        wb_we,
    input logic [4:0]  wb_reg,
    input logic [31:0] wb_dat,
    input logic [4:0]  src,
    input logic [31:0] reg_dat
  );
    logic [31:0] r;
    r = reg_dat;
    if (src != 5'd0) begin
      if (ex.reg_write && !ex.mem_read && (ex.write_reg == src)) begin
        r = ex.alu_result;
      end else if (wb_we && (wb_reg == src)) begin
        r = wb_dat;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative 32x32 shift-add multiplier (low 32 product bits), built only with EX_MUL_EN.
// Latency: start pulse loads operands, then MUL_CYCLES busy cycles; done flags the last one.
// Backpressure: none; product holds after completion until the next start.
`ifdef EX_MUL_EN
module ex_mul_iter
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam logic [4:0] LAST_STEP = 5'(MUL_CYCLES - 1);

  logic        run_q;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;

  // One partial product per cycle: add shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= 5'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= 5'd0;
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= 32'd0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 5'd1;
      if (cnt_q == LAST_STEP) begin
        run_q <= 1'b0;
      end
    end
  end

  assign busy    = run_q;
  assign done    = run_q && (cnt_q == LAST_STEP);
  assign product = acc_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// EX pipeline stage: bypassing, ALU, branch resolve, EX/MEM register; optional iterative MUL under EX_MUL_EN.
// Latency: 1 cycle for single-cycle ops; MUL holds EX_Busy for 33 cycles then writes in MUL_DONE.
// Backpressure: MemoryStall freezes EX/MEM (reset still wins); EX_Busy asks the hazard unit to hold ID/EX.
module ex_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_MemToReg,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MemWrite,
  input  logic        ID_EX_Branch,
  input  logic        ID_EX_ALUSrc,
  input  logic [5:0]  ID_EX_ALUOp,
  input  logic [31:0] ID_EX_BranchTarget,
  input  logic [31:0] ID_EX_ReadData1,
  input  logic [31:0] ID_EX_ReadData2,
  input  logic [31:0] ID_EX_SignExtImm,
  input  logic [4:0]  ID_EX_WriteReg,
  input  logic [4:0]  ID_EX_Rs,
  input  logic        MemoryStall,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] MEM_WB_WriteData,
  output logic        EX_MEM_MemToReg,
  output logic        EX_MEM_RegWrite,
  output logic        EX_MEM_MemRead,
  output logic        EX_MEM_MemWrite,
  output logic        EX_MEM_BranchTaken,
  output logic [31:0] EX_MEM_ALUResult,
  output logic [31:0] EX_MEM_StoreData,
  output logic [31:0] EX_MEM_BranchTarget,
  output logic [4:0]  EX_MEM_WriteReg,
  output logic        EX_Busy
);

  ex_mem_t     exmem_q;
  ex_mem_t     exmem_d;
  ex_mem_t     exmem_norm;
  ex_mem_t     mul_out;
  logic        mul_wb;
  logic        ex_busy;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] store_fwd;
  logic [31:0] alu_res;
  logic        op_valid;
  logic        taken;

  assign op_a      = fwd_operand(exmem_q, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_WriteData,
                                 ID_EX_Rs, ID_EX_ReadData1);
  assign op_b      = ID_EX_ALUSrc ? ID_EX_SignExtImm : ID_EX_ReadData2;
  // Store data is bypassed on the register named in the WriteReg field (the store source).
  assign store_fwd = fwd_operand(exmem_q, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_WriteData,
                                 ID_EX_WriteReg, ID_EX_ReadData2);

  // Single-cycle ALU; unknown codes (and MUL when the multiplier is not built) produce 0 and suppress writes.
  always_comb begin
    alu_res  = 32'd0;
    op_valid = 1'b1;
    case (ID_EX_ALUOp)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
`ifdef EX_MUL_EN
      ALU_MUL:  alu_res = 32'd0;
`else
      ALU_MUL:  op_valid = 1'b0;
`endif
      ALU_BEQZ, ALU_BNEZ, ALU_JMP, ALU_NOP: alu_res = 32'd0;
      default:  op_valid = 1'b0;
    endcase
  end

  // Branch resolution on the bypassed A operand.
  always_comb begin
    taken = 1'b0;
    if (ID_EX_Branch) begin
      taken = (ID_EX_ALUOp == ALU_JMP) ||
              ((ID_EX_ALUOp == ALU_BEQZ) && (op_a == 32'd0)) ||
              ((ID_EX_ALUOp == ALU_BNEZ) && (op_a != 32'd0));
    end
  end

  // Candidate EX/MEM contents for a normally issuing instruction.
  always_comb begin
    exmem_norm               = '0;
    exmem_norm.mem_to_reg    = ID_EX_MemToReg;
    exmem_norm.reg_write     = ID_EX_RegWrite & op_valid;
    exmem_norm.mem_read      = ID_EX_MemRead;
    exmem_norm.mem_write     = ID_EX_MemWrite & op_valid;
    exmem_norm.branch_taken  = taken;
    exmem_norm.alu_result    = alu_res;
    exmem_norm.store_data    = store_fwd;
    exmem_norm.branch_target = ID_EX_BranchTarget;
    exmem_norm.write_reg     = ID_EX_WriteReg;
  end

`ifdef EX_MUL_EN
  mul_state_e  state_q;
  mul_state_e  state_d;
  ex_mem_t     mul_ctrl_q;
  logic        mul_accept;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;

  // A MUL is only taken while EX/MEM can move, so a stalled MUL is not accepted twice.
  assign mul_accept = !rst && (state_q == IDLE) && (ID_EX_ALUOp == ALU_MUL) && !MemoryStall;

  // Multiply sequencer: next state, start pulse and stall request.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    ex_busy   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mul_accept) begin
          state_d   = MUL_RUN;
          mul_start = 1'b1;
          ex_busy   = 1'b1;
        end
      end
      MUL_RUN: begin
        ex_busy = 1'b1;
        if (mul_done || !mul_busy) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (!MemoryStall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the MUL's control fields at accept so later ID/EX changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_ctrl_q <= '0;
    end else if (mul_accept) begin
      mul_ctrl_q <= exmem_norm;
    end
  end

  ex_mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_wb = (state_q == MUL_DONE);

  // Product replaces the result field of the captured MUL entry.
  always_comb begin
    mul_out            = mul_ctrl_q;
    mul_out.alu_result = mul_product;
  end
`else
  assign ex_busy = 1'b0;
  assign mul_wb  = 1'b0;
  assign mul_out = '0;
`endif

  // Next EX/MEM: finished multiply, else bubble while busy, else the issuing instruction.
  always_comb begin
    exmem_d = exmem_norm;
    if (mul_wb) begin
      exmem_d = mul_out;
    end else if (ex_busy) begin
      exmem_d = '0;
    end
  end

  // EX/MEM register: reset beats stall, stall holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else if (!MemoryStall) begin
      exmem_q <= exmem_d;
    end
  end

  assign EX_MEM_MemToReg     = exmem_q.mem_to_reg;
  assign EX_MEM_RegWrite     = exmem_q.reg_write;
  assign EX_MEM_MemRead      = exmem_q.mem_read;
  assign EX_MEM_MemWrite     = exmem_q.mem_write;
  assign EX_MEM_BranchTaken  = exmem_q.branch_taken;
  assign EX_MEM_ALUResult    = exmem_q.alu_result;
  assign EX_MEM_StoreData    = exmem_q.store_data;
  assign EX_MEM_BranchTarget = exmem_q.branch_target;
  assign EX_MEM_WriteReg     = exmem_q.write_reg;
  assign EX_Busy             = ex_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU ops, bypassing, branches, stalls and MUL (EX_MUL_EN builds).
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: drives MemoryStall directly.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_EX_MemToReg, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
  logic        ID_EX_Branch, ID_EX_ALUSrc;
  logic [5:0]  ID_EX_ALUOp;
  logic [31:0] ID_EX_BranchTarget, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
  logic [4:0]  ID_EX_WriteReg, ID_EX_Rs;
  logic        MemoryStall;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_WB_WriteData;
  logic        EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic        EX_MEM_BranchTaken;
  logic [31:0] EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_BranchTarget;
  logic [4:0]  EX_MEM_WriteReg;
  logic        EX_Busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_BranchTarget(ID_EX_BranchTarget), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_SignExtImm(ID_EX_SignExtImm),
    .ID_EX_WriteReg(ID_EX_WriteReg), .ID_EX_Rs(ID_EX_Rs),
    .MemoryStall(MemoryStall), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_WriteReg(MEM_WB_WriteReg), .MEM_WB_WriteData(MEM_WB_WriteData),
    .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_BranchTaken(EX_MEM_BranchTaken), .EX_MEM_ALUResult(EX_MEM_ALUResult),
    .EX_MEM_StoreData(EX_MEM_StoreData), .EX_MEM_BranchTarget(EX_MEM_BranchTarget),
    .EX_MEM_WriteReg(EX_MEM_WriteReg), .EX_Busy(EX_Busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one plain instruction on ID/EX; branch/memory flags cleared.
  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] wr,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic alusrc, input logic we);
    ID_EX_ALUOp = op; ID_EX_Rs = rs; ID_EX_WriteReg = wr;
    ID_EX_ReadData1 = rd1; ID_EX_ReadData2 = rd2; ID_EX_SignExtImm = imm;
    ID_EX_ALUSrc = alusrc; ID_EX_RegWrite = we;
    ID_EX_MemToReg = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_MemWrite = 1'b0;
    ID_EX_Branch = 1'b0; ID_EX_BranchTarget = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; MemoryStall = 1'b0;
    MEM_WB_RegWrite = 1'b0; MEM_WB_WriteReg = 5'd0; MEM_WB_WriteData = 32'd0;
    drive(6'b000000, 5'd0, 5'd3, 32'd5, 32'd0, 32'd7, 1'b1, 1'b1);
    tick(); tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", EX_MEM_ALUResult); end
    n_cmp++; if (EX_MEM_RegWrite !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite got %b want 0", EX_MEM_RegWrite); end
    n_cmp++; if (EX_MEM_WriteReg !== 5'd0) begin n_bad++; $display("FAIL reset_writereg got %0d want 0", EX_MEM_WriteReg); end
    n_cmp++; if (EX_Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", EX_Busy); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive(6'b000000, 5'd1, 5'd3, 32'd5, 32'd0, 32'd7, 1'b1, 1'b1);
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd12) begin n_bad++; $display("FAIL add_result got %0d want 12", EX_MEM_ALUResult); end
    n_cmp++; if (EX_MEM_RegWrite !== 1'b1) begin n_bad++; $display("FAIL add_regwrite got %b want 1", EX_MEM_RegWrite); end
    n_cmp++; if (EX_MEM_WriteReg !== 5'd3) begin n_bad++; $display("FAIL add_writereg got %0d want 3", EX_MEM_WriteReg); end
  endtask

  task automatic test_back_to_back();
    // r3 = 10 + 20 = 30, then SUB r3 - 4 with MEM/WB also offering r3 = 99.
    drive(6'b000000, 5'd0, 5'd3, 32'd10, 32'd0, 32'd20, 1'b1, 1'b1);
    tick();
    drive(6'b000001, 5'd3, 5'd4, 32'd1, 32'd4, 32'd0, 1'b0, 1'b1);
    MEM_WB_RegWrite = 1'b1; MEM_WB_WriteReg = 5'd3; MEM_WB_WriteData = 32'd99;
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd26) begin n_bad++; $display("FAIL fwd_exmem got %0d want 26", EX_MEM_ALUResult); end
    // Only MEM/WB matches r5: 99 + 1.
    drive(6'b000000, 5'd5, 5'd6, 32'd2, 32'd0, 32'd1, 1'b1, 1'b1);
    MEM_WB_WriteReg = 5'd5;
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd100) begin n_bad++; $display("FAIL fwd_memwb got %0d want 100", EX_MEM_ALUResult); end
    // r0 never bypasses, even when both older stages claim to write it.
    drive(6'b000000, 5'd0, 5'd0, 32'd50, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    drive(6'b000000, 5'd0, 5'd1, 32'd3, 32'd0, 32'd4, 1'b1, 1'b1);
    MEM_WB_WriteReg = 5'd0; MEM_WB_WriteData = 32'd77;
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd7) begin n_bad++; $display("FAIL fwd_r0 got %0d want 7", EX_MEM_ALUResult); end
    MEM_WB_RegWrite = 1'b0;
    // A load in EX/MEM is not bypassed.
    drive(6'b000000, 5'd0, 5'd6, 32'h100, 32'd0, 32'd0, 1'b1, 1'b1);
    ID_EX_MemRead = 1'b1;
    tick();
    drive(6'b000000, 5'd6, 5'd2, 32'd8, 32'd0, 32'd1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd9) begin n_bad++; $display("FAIL fwd_load got %0d want 9", EX_MEM_ALUResult); end
    // Store data bypass on the WriteReg field.
    drive(6'b000000, 5'd0, 5'd7, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    drive(6'b000000, 5'd0, 5'd7, 32'd0, 32'd5, 32'd4, 1'b1, 1'b0);
    ID_EX_MemWrite = 1'b1;
    tick();
    n_cmp++; if (EX_MEM_StoreData !== 32'h1234) begin n_bad++; $display("FAIL store_fwd got %h want 1234", EX_MEM_StoreData); end
    n_cmp++; if (EX_MEM_MemWrite !== 1'b1) begin n_bad++; $display("FAIL store_memwrite got %b want 1", EX_MEM_MemWrite); end
    drive(6'b000000, 5'd0, 5'd8, 32'd0, 32'd5, 32'd4, 1'b1, 1'b0);
    ID_EX_MemWrite = 1'b1;
    tick();
    n_cmp++; if (EX_MEM_StoreData !== 32'd5) begin n_bad++; $display("FAIL store_plain got %h want 5", EX_MEM_StoreData); end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        we;
  } alu_vec_t;

  task automatic test_alu_ops();
    alu_vec_t v[12];
    v[0]  = '{6'b000001, 32'd5,        32'd7,         32'hFFFF_FFFE, 1'b1};
    v[1]  = '{6'b000010, 32'hF0F0,     32'hFF00,      32'hF000,      1'b1};
    v[2]  = '{6'b000011, 32'hF0F0,     32'h0F00,      32'hFFF0,      1'b1};
    v[3]  = '{6'b000100, 32'hFF,       32'h0F,        32'hF0,        1'b1};
    v[4]  = '{6'b000101, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b1};
    v[5]  = '{6'b000101, 32'd5,        32'hFFFF_FFFD, 32'd0,         1'b1};
    v[6]  = '{6'b000110, 32'd1,        32'h21,        32'd2,         1'b1};
    v[7]  = '{6'b000111, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b1};
    v[8]  = '{6'b000000, 32'hFFFF_FFFF, 32'd2,        32'd1,         1'b1};
    v[9]  = '{6'b111111, 32'd3,        32'd4,         32'd0,         1'b0};
    v[10] = '{6'b010101, 32'd3,        32'd4,         32'd0,         1'b1};
    v[11] = '{6'b001100, 32'd9,        32'd9,         32'd0,         1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(v[i].op, 5'd0, 5'd9, v[i].a, v[i].b, 32'd0, 1'b0, 1'b1);
      tick();
      n_cmp++; if (EX_MEM_ALUResult !== v[i].res) begin n_bad++; $display("FAIL alu_result[%0d] op=%b got %h want %h", i, v[i].op, EX_MEM_ALUResult, v[i].res); end
      n_cmp++; if (EX_MEM_RegWrite !== v[i].we) begin n_bad++; $display("FAIL alu_regwrite[%0d] op=%b got %b want %b", i, v[i].op, EX_MEM_RegWrite, v[i].we); end
    end
  endtask

  task automatic test_branch();
    drive(6'b001001, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    ID_EX_Branch = 1'b1; ID_EX_BranchTarget = 32'h40;
    tick();
    n_cmp++; if (EX_MEM_BranchTaken !== 1'b1) begin n_bad++; $display("FAIL beqz_taken got %b want 1", EX_MEM_BranchTaken); end
    n_cmp++; if (EX_MEM_BranchTarget !== 32'h40) begin n_bad++; $display("FAIL beqz_target got %h want 40", EX_MEM_BranchTarget); end
    drive(6'b010101, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (EX_MEM_BranchTaken !== 1'b0) begin n_bad++; $display("FAIL branch_pulse got %b want 0", EX_MEM_BranchTaken); end
    drive(6'b001010, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    ID_EX_Branch = 1'b1; ID_EX_BranchTarget = 32'h40;
    tick();
    n_cmp++; if (EX_MEM_BranchTaken !== 1'b0) begin n_bad++; $display("FAIL bnez_zero got %b want 0", EX_MEM_BranchTaken); end
    drive(6'b001010, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    ID_EX_Branch = 1'b1; ID_EX_BranchTarget = 32'h80;
    tick();
    n_cmp++; if (EX_MEM_BranchTaken !== 1'b1) begin n_bad++; $display("FAIL bnez_nonzero got %b want 1", EX_MEM_BranchTaken); end
    drive(6'b001011, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (EX_MEM_BranchTaken !== 1'b0) begin n_bad++; $display("FAIL jmp_nobranch got %b want 0", EX_MEM_BranchTaken); end
    ID_EX_Branch = 1'b1;
    tick();
    n_cmp++; if (EX_MEM_BranchTaken !== 1'b1) begin n_bad++; $display("FAIL jmp_taken got %b want 1", EX_MEM_BranchTaken); end
  endtask

  task automatic test_stall();
    drive(6'b000000, 5'd0, 5'd1, 32'd1, 32'd0, 32'd100, 1'b1, 1'b1);
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd101) begin n_bad++; $display("FAIL stall_pre got %0d want 101", EX_MEM_ALUResult); end
    drive(6'b000000, 5'd0, 5'd2, 32'd2, 32'd0, 32'd100, 1'b1, 1'b1);
    MemoryStall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (EX_MEM_ALUResult !== 32'd101 || EX_MEM_WriteReg !== 5'd1) begin n_bad++; $display("FAIL stall_hold[%0d] got %0d/r%0d want 101/r1", c, EX_MEM_ALUResult, EX_MEM_WriteReg); end
      n_cmp++; if (EX_Busy !== 1'b0) begin n_bad++; $display("FAIL stall_busy[%0d] got %b want 0", c, EX_Busy); end
    end
    MemoryStall = 1'b0;
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd102 || EX_MEM_WriteReg !== 5'd2) begin n_bad++; $display("FAIL stall_resume got %0d/r%0d want 102/r2", EX_MEM_ALUResult, EX_MEM_WriteReg); end
    drive(6'b000000, 5'd0, 5'd3, 32'd3, 32'd0, 32'd100, 1'b1, 1'b1);
    tick();
    n_cmp++; if (EX_MEM_ALUResult !== 32'd103) begin n_bad++; $display("FAIL stall_next got %0d want 103", EX_MEM_ALUResult); end
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int busy_n;
    int bubbles_bad;
    drive(6'b001000, 5'd0, 5'd9, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1);
    #1;
    n_cmp++; if (EX_Busy !== 1'b1) begin n_bad++; $display("FAIL mul_accept_busy got %b want 1", EX_Busy); end
    busy_n = 1; bubbles_bad = 0;
    tick();
    ID_EX_ReadData1 = 32'd100; ID_EX_WriteReg = 5'd2;
    while (EX_Busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      if (EX_MEM_RegWrite !== 1'b0) bubbles_bad++;
      tick();
    end
    n_cmp++; if (busy_n !== 33) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want 33", busy_n); end
    n_cmp++; if (bubbles_bad !== 0) begin n_bad++; $display("FAIL mul_bubbles got %0d non-bubbles want 0", bubbles_bad); end
    tick();
    drive(6'b010101, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    n_cmp++; if (EX_MEM_ALUResult !== 32'd42) begin n_bad++; $display("FAIL mul_result got %0d want 42", EX_MEM_ALUResult); end
    n_cmp++; if (EX_MEM_RegWrite !== 1'b1 || EX_MEM_WriteReg !== 5'd9) begin n_bad++; $display("FAIL mul_ctrl got we=%b r%0d want we=1 r9", EX_MEM_RegWrite, EX_MEM_WriteReg); end
  endtask

  task automatic test_mul_reset();
    int seen;
    drive(6'b001000, 5'd0, 5'd9, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1);
    tick();
    repeat (10) tick();
    rst = 1'b1;
    drive(6'b010101, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (EX_Busy !== 1'b0 || EX_MEM_ALUResult !== 32'd0 || EX_MEM_RegWrite !== 1'b0) begin n_bad++; $display("FAIL mul_rst_state got busy=%b res=%0d we=%b want 0/0/0", EX_Busy, EX_MEM_ALUResult, EX_MEM_RegWrite); end
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (EX_MEM_ALUResult === 32'd42 || EX_Busy !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mul_rst_abort got %0d late results want 0", seen); end
  endtask
`else
  task automatic test_mul();
    drive(6'b001000, 5'd0, 5'd9, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1);
    #1;
    n_cmp++; if (EX_Busy !== 1'b0) begin n_bad++; $display("FAIL mul_off_busy got %b want 0", EX_Busy); end
    tick();
    n_cmp++; if (EX_MEM_RegWrite !== 1'b0 || EX_MEM_ALUResult !== 32'd0) begin n_bad++; $display("FAIL mul_off_result got we=%b res=%0d want 0/0", EX_MEM_RegWrite, EX_MEM_ALUResult); end
  endtask

  task automatic test_mul_reset();
    rst = 1'b1;
    drive(6'b010101, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (EX_Busy !== 1'b0 || EX_MEM_ALUResult !== 32'd0) begin n_bad++; $display("FAIL rst_again got busy=%b res=%0d want 0/0", EX_Busy, EX_MEM_ALUResult); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_branch();
    test_stall();
    test_mul();
    test_mul_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock; rst in 1, reset; one clock, synchronous active-high reset.
REQ-002 SHALL accept ID/EX inputs: ID_EX_MemToReg, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUSrc in 1; ID_EX_ALUOp in 6; ID_EX_BranchTarget, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm in 32; ID_EX_WriteReg, ID_EX_Rs in 5.
REQ-003 SHALL accept MemoryStall in 1, freeze request; MEM_WB_RegWrite in 1; MEM_WB_WriteReg in 5; MEM_WB_WriteData in 32, writeback forwarding source.
REQ-004 SHALL drive registered EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_BranchTaken out 1; EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_BranchTarget out 32; EX_MEM_WriteReg out 5.
REQ-005 SHALL drive EX_Busy out 1, combinational stall request to hazard unit.

Function
REQ-006 SHALL select operand A: EX_MEM_RegWrite & !EX_MEM_MemRead & EX_MEM_WriteReg==ID_EX_Rs & Rs!=0 -> EX_MEM_ALUResult; else MEM_WB_RegWrite & match & Rs!=0 -> MEM_WB_WriteData; else ID_EX_ReadData1; EX/MEM wins on double match.
REQ-007 SHALL select operand B = ID_EX_ALUSrc ? ID_EX_SignExtImm : ID_EX_ReadData2.
REQ-008 SHALL forward store data by REQ-006 rule keyed on ID_EX_WriteReg into EX_MEM_StoreData.
REQ-009 SHALL implement ALUOp: ADD 000000, SUB 000001, AND 000010, OR 000011, XOR 000100, SLT 000101 (signed, result 0/1), SLL 000110, SRL 000111 (shift amount B[4:0]), MUL 001000, BEQZ 001001, BNEZ 001010, JMP 001011, NOP 010101; undefined codes -> result 0, no write.
REQ-010 SHALL compute 32-bit wrap-around arithmetic, no overflow flag.
REQ-011 SHALL set EX_MEM_BranchTaken = ID_EX_Branch & (JMP | BEQZ & A==0 | BNEZ & A!=0), registered with ID_EX_BranchTarget; pulse lasts one cycle per branch.
REQ-012 SHALL update EX/MEM register each clk when !MemoryStall & !EX_Busy; single-cycle ops have latency 1.
REQ-013 SHALL hold all EX/MEM outputs unchanged while MemoryStall=1.
REQ-014 SHALL run MUL FSM IDLE -> MUL_RUN (32 shift-add cycles, 5-bit counter) -> MUL_DONE -> IDLE; EX_Busy=1 in IDLE on MUL accept and in MUL_RUN.
REQ-015 SHALL load EX/MEM with bubble (all control 0) each cycle EX_Busy=1 and MemoryStall=0.
REQ-016 SHALL in MUL_DONE write low 32 product bits with MUL control; stay in MUL_DONE while MemoryStall=1.
REQ-017 SHALL latch multiplier operands at accept; later changes to ID_EX inputs are ignored until MUL_DONE.

Reset
REQ-018 SHALL on rst at clk edge clear every EX/MEM output to 0, FSM to IDLE, counter to 0, EX_Busy to 0.
REQ-019 SHALL abort an in-flight multiply on rst with no result written.
REQ-020 SHALL give rst priority over MemoryStall and FSM.

Configuration
REQ-021 SHALL with EX_MUL_EN defined instantiate FSM/multiplier per REQ-014..017.
REQ-022 SHALL without EX_MUL_EN treat MUL as undefined (result 0, RegWrite 0), tie EX_Busy 0, omit multiplier logic.

Structure
REQ-023 SHALL place ALUOp codes, NOP code, FSM state encoding and MUL_CYCLES=32 in shared package cpu_pkg.
REQ-024 SHALL implement multiplier as sub-module ex_mul_iter (start, a, b -> busy, done, product).

Verification
REQ-025 ADD, ReadData1=5, imm=7, ALUSrc=1 -> next cycle EX_MEM_ALUResult=12, RegWrite=1.
REQ-026 Back-to-back ADD r3 then SUB using Rs=r3, MEM_WB also matching r3=99 -> EX/MEM value used.
REQ-027 BEQZ Rs=0, target 0x40 -> EX_MEM_BranchTaken=1 one cycle, EX_MEM_BranchTarget=0x40; BNEZ same -> 0.
REQ-028 MUL 7x6 with EX_MUL_EN -> EX_Busy high 33 cycles, bubbles, then ALUResult=42; without macro -> RegWrite=0, Busy=0.
REQ-029 MemoryStall=1 for 3 cycles mid-stream -> EX/MEM outputs frozen, resume with no loss/duplication.
REQ-030 rst at MUL_RUN cycle 10 -> outputs 0, FSM IDLE, no product written.
